// File: rtl/window_3x3_gen.sv
// window_3x3_gen: raster RGB444 stream to black-padded 3x3 windows.
// Two line buffers feed a register window; the frame tail is flushed autonomously.
module window_3x3_gen #(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [11:0]                   in_pixel,
   input  logic                          in_valid,
   input  logic                          in_sof,
   output logic                          in_ready,
   output logic [107:0]                  color_data,
   output logic                          out_valid,
   output logic [$clog2(IMG_WIDTH)-1:0]  out_x,
   output logic [$clog2(IMG_HEIGHT)-1:0] out_y,
   output logic                          out_eof
);
   localparam int XW = $clog2(IMG_WIDTH);
   localparam int YW = $clog2(IMG_HEIGHT);
   localparam int D  = IMG_WIDTH + 1;
   localparam int FW = $clog2(D + 1);
   localparam logic [XW-1:0] XMAX = XW'(IMG_WIDTH - 1);
   localparam logic [YW-1:0] YMAX = YW'(IMG_HEIGHT - 1);
   localparam logic [FW-1:0] FLEN = FW'(D);

   typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

   state_t        state, state_nx;
   logic [11:0]   lb_a [IMG_WIDTH];
   logic [11:0]   lb_b [IMG_WIDTH];
   logic [11:0]   bot0, bot1, mid0, mid1, top0, top1;
   logic [XW-1:0] in_x, cx, ptr;
   logic [YW-1:0] in_y, cy;
   logic [FW-1:0] fcnt;
   logic          acc, sof_acc, flush_em, emit, shift, last_in, eof_nx;
   logic [11:0]   pix, a_rd, b_rd;
   logic          l_ok, r_ok, u_ok, d_ok;
   logic [107:0]  win;

   always_comb begin
      acc      = in_valid & in_ready;
      sof_acc  = acc & in_sof;
      flush_em = (state == FLUSH) && (fcnt < FLEN);
      emit     = ((state == RUN) && acc && !in_sof) || flush_em;
      shift    = sof_acc || flush_em
               || (acc && (state == FILL || state == RUN));
      last_in  = (in_x == XMAX) && (in_y == YMAX);
      ptr      = sof_acc ? '0 : in_x;
      pix      = (state == FLUSH) ? 12'h000 : in_pixel;
      a_rd     = lb_a[ptr];
      b_rd     = lb_b[ptr];
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:  if (sof_acc) state_nx = FILL;
         FILL: begin
            if (sof_acc)
               state_nx = FILL;
            else if (acc && in_x == '0 && in_y == YW'(1))
               state_nx = RUN;
         end
         RUN: begin
            if (sof_acc)
               state_nx = FILL;
            else if (acc && last_in)
               state_nx = FLUSH;
         end
         FLUSH: if (fcnt == FLEN) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Neighbours outside the image are masked by centre position, not by data age.
   always_comb begin
      l_ok   = cx != '0;
      r_ok   = cx != XMAX;
      u_ok   = cy != '0;
      d_ok   = cy != YMAX;
      eof_nx = (cx == XMAX) && (cy == YMAX);
      win = {mid0,
             {12{l_ok}} & mid1,
             {12{r_ok}} & a_rd,
             {12{u_ok}} & top0,
             {12{d_ok}} & bot0,
             {12{u_ok & l_ok}} & top1,
             {12{u_ok & r_ok}} & b_rd,
             {12{d_ok & l_ok}} & bot1,
             {12{d_ok & r_ok}} & pix};
   end

   always_ff @(posedge clk) begin
      if (shift) begin
         lb_a[ptr] <= pix;
         lb_b[ptr] <= a_rd;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         in_ready <= 1'b0;
         fcnt     <= '0;
         in_x     <= '0;
         in_y     <= '0;
         cx       <= '0;
         cy       <= '0;
         bot0     <= '0;
         bot1     <= '0;
         mid0     <= '0;
         mid1     <= '0;
         top0     <= '0;
         top1     <= '0;
      end else begin
         state    <= state_nx;
         in_ready <= state_nx != FLUSH;
         fcnt     <= (state == FLUSH) ? fcnt + FW'(1) : '0;
         if (shift) begin
            bot0 <= pix;
            bot1 <= bot0;
            mid0 <= a_rd;
            mid1 <= mid0;
            top0 <= b_rd;
            top1 <= top0;
            if (sof_acc) begin
               in_x <= XW'(1);
               in_y <= '0;
            end else if (in_x == XMAX) begin
               in_x <= '0;
               in_y <= (in_y == YMAX) ? '0 : in_y + YW'(1);
            end else begin
               in_x <= in_x + XW'(1);
            end
         end
         if (sof_acc) begin
            cx <= '0;
            cy <= '0;
         end else if (emit) begin
            if (cx == XMAX) begin
               cx <= '0;
               cy <= (cy == YMAX) ? '0 : cy + YW'(1);
            end else begin
               cx <= cx + XW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid  <= 1'b0;
         color_data <= '0;
         out_x      <= '0;
         out_y      <= '0;
         out_eof    <= 1'b0;
      end else begin
         out_valid <= emit;
         if (emit) begin
            color_data <= win;
            out_x      <= cx;
            out_y      <= cy;
            out_eof    <= eof_nx;
         end
      end
   end

endmodule

// File: tb/tb_window_3x3_gen.sv
// tb_window_3x3_gen: scoreboard bench for window_3x3_gen at W=4, H=3.
// Expected windows come from a coordinate-level model of the stored frame.
module tb_window_3x3_gen;
   localparam int W = 4;
   localparam int H = 3;
   localparam int D = W + 1;
   localparam int N = W * H;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic [11:0]  in_pixel = '0;
   logic         in_valid = 1'b0;
   logic         in_sof = 1'b0;
   logic         in_ready, out_valid, out_eof;
   logic [107:0] color_data;
   logic [1:0]   out_x, out_y;

   typedef struct {
      logic [107:0] d;
      int           x;
      int           y;
      bit           eof;
      int           cyc;
      bit           fl;
   } exp_t;

   exp_t         sb[$];
   exp_t         mon_e;
   logic [107:0] wlog[$];
   bit           elog[$];
   logic [11:0]  frm [N];
   int           checks = 0;
   int           failures = 0;
   int           cyc = 0;
   int           nb;
   int           neof;

   window_3x3_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
      .clk(clk), .reset(reset),
      .in_pixel(in_pixel), .in_valid(in_valid), .in_sof(in_sof),
      .in_ready(in_ready), .color_data(color_data), .out_valid(out_valid),
      .out_x(out_x), .out_y(out_y), .out_eof(out_eof)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h", nm, act, exp);
      end
   endtask

   function automatic logic [11:0] px(input int x, input int y);
      if (x < 0 || x >= W || y < 0 || y >= H) return 12'h000;
      return frm[y * W + x];
   endfunction

   function automatic logic [107:0] model(input int c);
      int x, y;
      x = c % W;
      y = c / W;
      return {px(x, y), px(x - 1, y), px(x + 1, y), px(x, y - 1),
              px(x, y + 1), px(x - 1, y - 1), px(x + 1, y - 1),
              px(x - 1, y + 1), px(x + 1, y + 1)};
   endfunction

   task automatic push(input int c, input int at, input bit fl);
      exp_t e;
      e.d   = model(c);
      e.x   = c % W;
      e.y   = c / W;
      e.eof = (c == N - 1);
      e.cyc = at;
      e.fl  = fl;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      if (!reset && out_valid) begin
         wlog.push_back(color_data);
         elog.push_back(out_eof);
         if (sb.size() == 0) begin
            chk("unexpected_out_valid", 1, 0);
         end else begin
            mon_e = sb.pop_front();
            chk("window", color_data, mon_e.d);
            chk("out_x", out_x, mon_e.x);
            chk("out_y", out_y, mon_e.y);
            chk("out_eof", out_eof, mon_e.eof);
            chk("out_cycle", cyc, mon_e.cyc);
            if (mon_e.fl) chk("flush_in_ready", in_ready, 0);
         end
      end
   end

   task automatic send_frame(input int gap, input int abort_at, input bit seq);
      int n, guard;
      n = 0;
      guard = 0;
      for (int i = 0; i < N; i++) frm[i] = seq ? 12'(i) : 12'($urandom);
      while (n < N && guard < 1000) begin
         @(negedge clk);
         guard++;
         if (abort_at > 0 && n == abort_at) begin
            in_valid = 1'b0;
            in_sof   = 1'b0;
            return;
         end
         in_valid = ($urandom_range(99) >= gap);
         in_sof   = (n == 0);
         in_pixel = frm[n];
         if (in_valid && in_ready) begin
            if (n >= D) push(n - D, cyc + 1, 1'b0);
            if (n == N - 1)
               for (int k = 0; k < D; k++) push(N - D + k, cyc + 2 + k, 1'b1);
            n++;
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_sof   = 1'b0;
      chk("frame_done", n, N);
   endtask

   task automatic wait_idle();
      int g;
      g = 0;
      while ((sb.size() != 0 || !in_ready) && g < 200) begin
         @(negedge clk);
         g++;
      end
      chk("drain_in_time", g < 200, 1);
   endtask

   initial begin
      #1 reset = 1'b1;
      #1;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_color_data", color_data, 0);
      chk("rst_out_x", out_x, 0);
      chk("rst_out_y", out_y, 0);
      chk("rst_out_eof", out_eof, 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("ready_after_reset", in_ready, 1);

      // pixel value = index, gapless
      wlog.delete();
      elog.delete();
      send_frame(0, 0, 1'b1);
      wait_idle();
      chk("win_count", wlog.size(), N);
      chk("first_window", wlog[0],
          {12'h000, 12'h000, 12'h001, 12'h000, 12'h004,
           12'h000, 12'h000, 12'h000, 12'h005});
      chk("right_edge_window", wlog[7],
          {12'h007, 12'h006, 12'h000, 12'h003, 12'h00B,
           12'h002, 12'h000, 12'h00A, 12'h000});
      chk("last_window", wlog[11],
          {12'h00B, 12'h00A, 12'h000, 12'h007, 12'h000,
           12'h006, 12'h000, 12'h000, 12'h000});
      chk("last_eof", elog[11], 1);
      chk("prev_no_eof", elog[10], 0);

      // same frame with ~50% gaps
      wlog.delete();
      send_frame(50, 0, 1'b1);
      wait_idle();
      chk("gap_win_count", wlog.size(), N);

      // mid-frame restart at n=6
      wlog.delete();
      elog.delete();
      send_frame(0, 6, 1'b1);
      send_frame(0, 0, 1'b0);
      wait_idle();
      neof = 0;
      foreach (elog[i]) if (elog[i]) neof++;
      chk("abort_eof_count", neof, 1);
      chk("abort_win_count", wlog.size(), N + 1);

      for (int r = 0; r < 4; r++) begin
         send_frame(r * 25, 0, 1'b0);
         wait_idle();
      end

      // reset during flush
      send_frame(0, 0, 1'b1);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("flush_rst_out_valid", out_valid, 0);
      chk("flush_rst_color_data", color_data, 0);
      chk("flush_rst_out_x", out_x, 0);
      chk("flush_rst_out_y", out_y, 0);
      chk("flush_rst_out_eof", out_eof, 0);
      chk("flush_rst_in_ready", in_ready, 0);
      sb.delete();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("release_in_ready_low", in_ready, 0);
      @(negedge clk);
      chk("release_in_ready_high", in_ready, 1);
      nb = wlog.size();
      for (int i = 0; i < 20; i++) begin
         in_valid = 1'b1;
         in_sof   = 1'b0;
         in_pixel = 12'($urandom);
         @(negedge clk);
      end
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("non_sof_ignored", wlog.size() - nb, 0);

      send_frame(30, 0, 1'b0);
      wait_idle();
      repeat (3) @(negedge clk);
      chk("scoreboard_empty", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
